// File: rtl/ffn_sched_pkg.sv
// Shared state encoding and buffer-select codes for the FFN tile fetch scheduler.
package ffn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RST_ADDR   = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT_FETCH = 3'd3,
    S_WAIT_BANK  = 3'd4,
    S_DRAIN      = 3'd5,
    S_DONE       = 3'd6
  } sched_state_e;

  localparam logic [3:0] BUF_ID_NONE    = 4'd0;
  localparam logic [3:0] BUF_ID_FFN_WBI = 4'd3;

  function automatic logic [1:0] bank_onehot(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ffn_bank_tracker.sv
// Per-bank "tile ready" flags: set by a completed fetch, cleared by the consumer.
module ffn_bank_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] set_i,
  input  logic [1:0] release_i,
  output logic [1:0] full_o,
  output logic [1:0] full_after_rel_o,
  output logic       empty_rel_err_o
);

  logic [1:0] full_q;
  logic [1:0] full_d;

  // A release aimed at an empty bank is a no-op on the flags but is flagged;
  // a simultaneous set on that bank still lands.
  always_comb begin
    full_after_rel_o = full_q & ~release_i;
    full_d           = full_after_rel_o | set_i;
    empty_rel_err_o  = |(release_i & ~full_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

  assign full_o = full_q;

endmodule

// File: rtl/ffn_tile_fetch_scheduler.sv
// Issues one tile fetch at a time into a ping-pong bank pair and tracks which
// banks hold tiles still waiting for the compute array.
module ffn_tile_fetch_scheduler
  import ffn_sched_pkg::*;
#(
  parameter int unsigned              BUF_SEL_WIDTH  = 4,
  parameter logic [BUF_SEL_WIDTH-1:0] BUFFER_ID      = BUF_SEL_WIDTH'(BUF_ID_FFN_WBI),
  parameter int unsigned              TILE_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_start,
  input  logic [TILE_CNT_WIDTH-1:0] job_num_tiles,
  input  logic                      db_en,
  output logic                      job_busy,
  output logic                      job_done,
  output logic                      start_fetch,
  output logic                      reset_addr_counter,
  output logic [BUF_SEL_WIDTH-1:0]  Buffer_Select,
  output logic                      Tiles_Control,
  output logic                      Double_buffering,
  input  logic                      fetch_done,
  input  logic                      fetch_busy,
  output logic [1:0]                bank_full,
  input  logic [1:0]                bank_release,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx,
  output logic                      protocol_err
);

  sched_state_e              state_q, state_d;
  logic [TILE_CNT_WIDTH-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_CNT_WIDTH-1:0] num_tiles_q, num_tiles_d;
  logic                      fill_bank_q, fill_bank_d;
  logic                      db_en_q, db_en_d;
  logic                      err_q, err_d;
  logic [1:0]                bank_set_s;
  logic [1:0]                full_after_rel_s;
  logic                      empty_rel_err_s;
  logic                      last_tile_s;

  ffn_bank_tracker u_bank_tracker (
    .clk              (clk),
    .rst              (rst),
    .set_i            (bank_set_s),
    .release_i        (bank_release),
    .full_o           (bank_full),
    .full_after_rel_o (full_after_rel_s),
    .empty_rel_err_o  (empty_rel_err_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tile_idx_q  <= '0;
      num_tiles_q <= '0;
      fill_bank_q <= 1'b0;
      db_en_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tile_idx_q  <= tile_idx_d;
      num_tiles_q <= num_tiles_d;
      fill_bank_q <= fill_bank_d;
      db_en_q     <= db_en_d;
      err_q       <= err_d;
    end
  end

  assign last_tile_s = (tile_idx_q == (num_tiles_q - TILE_CNT_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    tile_idx_d  = tile_idx_q;
    num_tiles_d = num_tiles_q;
    fill_bank_d = fill_bank_q;
    db_en_d     = db_en_q;
    bank_set_s  = 2'b00;
    err_d       = err_q | empty_rel_err_s | (fetch_done & (state_q != S_WAIT_FETCH));
    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          num_tiles_d = job_num_tiles;
          db_en_d     = db_en;
          if (job_num_tiles != '0) begin
            state_d     = S_RST_ADDR;
            tile_idx_d  = '0;
            fill_bank_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RST_ADDR: state_d = S_WAIT_BANK;
      S_WAIT_BANK: begin
        if (!full_after_rel_s[fill_bank_q]) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT_BANK;
        end
      end
      S_ISSUE: begin
        if (!fetch_busy) begin
          state_d = S_WAIT_FETCH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_FETCH: begin
        if (fetch_done) begin
          bank_set_s = bank_onehot(fill_bank_q);
          if (last_tile_s) begin
            state_d = S_DRAIN;
          end else begin
            tile_idx_d  = tile_idx_q + TILE_CNT_WIDTH'(1);
            fill_bank_d = db_en_q ? ~fill_bank_q : 1'b0;
            state_d     = S_WAIT_BANK;
          end
        end else begin
          state_d = S_WAIT_FETCH;
        end
      end
      S_DRAIN: begin
        if (full_after_rel_s == 2'b00) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // start_fetch is additionally gated so it can never coincide with a busy fetch engine.
  always_comb begin
    job_busy           = (state_q != S_IDLE);
    job_done           = (state_q == S_DONE);
    reset_addr_counter = (state_q == S_RST_ADDR);
    start_fetch        = (state_q == S_ISSUE) & ~fetch_busy;
    Buffer_Select      = job_busy ? BUFFER_ID : '0;
    Tiles_Control      = fill_bank_q;
    Double_buffering   = db_en_q;
    tile_idx           = tile_idx_q;
    protocol_err       = err_q;
  end

endmodule

// File: tb/tb_ffn_tile_fetch_scheduler.sv
// Directed self-checking bench for ffn_tile_fetch_scheduler.
module tb_ffn_tile_fetch_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       job_start = 1'b0;
  logic [7:0] job_num_tiles = 8'd0;
  logic       db_en = 1'b0;
  logic       job_busy, job_done, start_fetch, reset_addr_counter;
  logic [3:0] Buffer_Select;
  logic       Tiles_Control, Double_buffering;
  logic       fetch_done = 1'b0;
  logic       fetch_busy = 1'b0;
  logic [1:0] bank_full;
  logic [1:0] bank_release = 2'b00;
  logic [7:0] tile_idx;
  logic       protocol_err;

  int n_checks = 0;
  int n_errors = 0;
  int sf_cnt   = 0;
  int sf_base  = 0;

  ffn_tile_fetch_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .job_start          (job_start),
    .job_num_tiles      (job_num_tiles),
    .db_en              (db_en),
    .job_busy           (job_busy),
    .job_done           (job_done),
    .start_fetch        (start_fetch),
    .reset_addr_counter (reset_addr_counter),
    .Buffer_Select      (Buffer_Select),
    .Tiles_Control      (Tiles_Control),
    .Double_buffering   (Double_buffering),
    .fetch_done         (fetch_done),
    .fetch_busy         (fetch_busy),
    .bank_full          (bank_full),
    .bank_release       (bank_release),
    .tile_idx           (tile_idx),
    .protocol_err       (protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start_fetch) sf_cnt <= sf_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input logic [7:0] n, input logic d);
    job_num_tiles = n;
    db_en         = d;
    job_start     = 1'b1;
    step();
    job_start     = 1'b0;
  endtask

  task automatic pulse_fd();
    fetch_done = 1'b1;
    step();
    fetch_done = 1'b0;
  endtask

  task automatic pulse_rel(input logic [1:0] b);
    bank_release = b;
    step();
    bank_release = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, job_busy, 0);
    check_val({tag, "_done"}, job_done, 0);
    check_val({tag, "_sf"}, start_fetch, 0);
    check_val({tag, "_rac"}, reset_addr_counter, 0);
    check_val({tag, "_bsel"}, Buffer_Select, 0);
    check_val({tag, "_tc"}, Tiles_Control, 0);
    check_val({tag, "_db"}, Double_buffering, 0);
    check_val({tag, "_full"}, bank_full, 0);
    check_val({tag, "_idx"}, tile_idx, 0);
    check_val({tag, "_err"}, protocol_err, 0);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    check_all_zero("rst");

    // Empty job: done at cycle 1, nothing fetched.
    start_job(8'd0, 1'b0);
    check_val("empty_done", job_done, 1);
    check_val("empty_busy", job_busy, 1);
    check_val("empty_rac", reset_addr_counter, 0);
    check_val("empty_sf", start_fetch, 0);
    step();
    check_val("empty_done2", job_done, 0);
    check_val("empty_busy2", job_busy, 0);

    // Single-bank job, N=3.
    sf_base = sf_cnt;
    start_job(8'd3, 1'b0);
    check_val("sb_rac", reset_addr_counter, 1);
    check_val("sb_busy", job_busy, 1);
    check_val("sb_bsel", Buffer_Select, 3);
    step();
    check_val("sb_c2_sf", start_fetch, 0);
    step();
    check_val("sb_c3_sf", start_fetch, 1);
    for (int t = 0; t < 3; t++) begin
      check_val("sb_tc", Tiles_Control, 0);
      check_val("sb_idx", tile_idx, t);
      step(10);
      pulse_fd();
      check_val("sb_full", bank_full, 2'b01);
      step(4);
      bank_release = 2'b01;
      check_val("sb_hold_sf", start_fetch, 0);
      check_val("sb_hold_done", job_done, 0);
      step();
      bank_release = 2'b00;
      check_val("sb_full_clr", bank_full, 2'b00);
      if (t < 2) check_val("sb_restart_sf", start_fetch, 1);
      else       check_val("sb_job_done", job_done, 1);
    end
    step();
    check_val("sb_busy_end", job_busy, 0);
    check_val("sb_bsel_end", Buffer_Select, 0);
    check_val("sb_sf_count", sf_cnt - sf_base, 3);
    check_val("sb_err", protocol_err, 0);

    // Ping-pong job, N=4; consumer only releases once both banks are full.
    start_job(8'd4, 1'b1);
    check_val("pp_db", Double_buffering, 1);
    step(2);
    check_val("pp_sf0", start_fetch, 1);
    check_val("pp_tc0", Tiles_Control, 0);
    step();
    pulse_fd();
    check_val("pp_full0", bank_full, 2'b01);
    check_val("pp_tc1", Tiles_Control, 1);
    step();
    check_val("pp_sf1_t2", start_fetch, 1);
    step();
    pulse_fd();
    check_val("pp_full1", bank_full, 2'b11);
    check_val("pp_tc2", Tiles_Control, 0);
    check_val("pp_idx2", tile_idx, 2);
    step(3);
    check_val("pp_stall", start_fetch, 0);
    pulse_rel(2'b01);
    check_val("pp_sf2", start_fetch, 1);
    check_val("pp_full2", bank_full, 2'b10);
    step();
    pulse_fd();
    check_val("pp_tc3", Tiles_Control, 1);
    check_val("pp_idx3", tile_idx, 3);
    pulse_rel(2'b10);
    check_val("pp_sf3", start_fetch, 1);
    step();
    pulse_fd();
    check_val("pp_drain_full", bank_full, 2'b11);
    pulse_rel(2'b01);
    check_val("pp_drain_wait", job_done, 0);
    pulse_rel(2'b10);
    check_val("pp_done", job_done, 1);
    step();
    check_val("pp_busy_end", job_busy, 0);
    check_val("pp_err", protocol_err, 0);

    // Protocol errors.
    pulse_rel(2'b10);
    check_val("err_empty_rel", protocol_err, 1);
    check_val("err_full_kept", bank_full, 2'b00);
    step(2);
    check_val("err_sticky", protocol_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("err_rst_clr", protocol_err, 0);
    pulse_fd();
    check_val("err_stray_fd", protocol_err, 1);
    step(3);
    check_val("err_sticky2", protocol_err, 1);

    // Reset during WAIT_FETCH of tile 2.
    start_job(8'd4, 1'b1);
    step(2);
    step();
    pulse_fd();
    step(2);
    pulse_fd();
    pulse_rel(2'b01);
    step();
    check_val("mid_idx", tile_idx, 2);
    check_val("mid_full", bank_full, 2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("mid_rst");

    // New job after reset, with fetch_busy held for 4 cycles at ISSUE.
    start_job(8'd1, 1'b0);
    check_val("fb_rac", reset_addr_counter, 1);
    step();
    fetch_busy = 1'b1;
    step();
    check_val("fb_sf_c3", start_fetch, 0);
    job_num_tiles = 8'd5;
    job_start     = 1'b1;
    step();
    job_start = 1'b0;
    check_val("fb_sf_c4", start_fetch, 0);
    check_val("fb_rac_ign", reset_addr_counter, 0);
    step(2);
    check_val("fb_sf_c6", start_fetch, 0);
    step();
    fetch_busy = 1'b0;
    #1;
    check_val("fb_sf_c7", start_fetch, 1);
    step();
    pulse_fd();
    check_val("fb_full", bank_full, 2'b01);
    check_val("fb_idx", tile_idx, 0);
    pulse_rel(2'b01);
    check_val("fb_done", job_done, 1);
    step();
    check_val("fb_busy_end", job_busy, 0);
    check_val("fb_err", protocol_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
